// File: rtl/jtag_axi_pkg.sv
// rtl/jtag_axi_pkg.sv - shared JTAG host types: host FSM codes, TAP states, IR decoding
package jtag_axi_pkg;

  localparam int DIV_CNT_W = 8;

  typedef logic [3:0] host_state_t;
  localparam host_state_t ST_INIT     = 4'd0;
  localparam host_state_t ST_IDLE     = 4'd1;
  localparam host_state_t ST_IR_NAV   = 4'd2;
  localparam host_state_t ST_IR_SHIFT = 4'd3;
  localparam host_state_t ST_IR_EXIT  = 4'd4;
  localparam host_state_t ST_DR_NAV   = 4'd5;
  localparam host_state_t ST_DR_SHIFT = 4'd6;
  localparam host_state_t ST_DR_EXIT  = 4'd7;
  localparam host_state_t ST_RESP     = 4'd8;

  typedef enum logic [3:0] {
    TAP_RESET, TAP_IDLE,
    TAP_SEL_DR, TAP_CAP_DR, TAP_SHIFT_DR, TAP_EXIT1_DR, TAP_PAUSE_DR, TAP_EXIT2_DR, TAP_UPD_DR,
    TAP_SEL_IR, TAP_CAP_IR, TAP_SHIFT_IR, TAP_EXIT1_IR, TAP_PAUSE_IR, TAP_EXIT2_IR, TAP_UPD_IR
  } tap_ctrl_fsm_t;

  typedef enum logic [3:0] {
    IR_IDCODE       = 4'h1,
    IR_ADDR_AXI_REG = 4'h8,
    IR_BYPASS       = 4'hF
  } ir_decoding_t;

  // IEEE 1149.1 TAP controller next-state on a rising TCK.
  function automatic tap_ctrl_fsm_t tap_next(tap_ctrl_fsm_t s, logic tms);
    case (s)
      TAP_RESET:    return tms ? TAP_RESET    : TAP_IDLE;
      TAP_IDLE:     return tms ? TAP_SEL_DR   : TAP_IDLE;
      TAP_SEL_DR:   return tms ? TAP_SEL_IR   : TAP_CAP_DR;
      TAP_CAP_DR:   return tms ? TAP_EXIT1_DR : TAP_SHIFT_DR;
      TAP_SHIFT_DR: return tms ? TAP_EXIT1_DR : TAP_SHIFT_DR;
      TAP_EXIT1_DR: return tms ? TAP_UPD_DR   : TAP_PAUSE_DR;
      TAP_PAUSE_DR: return tms ? TAP_EXIT2_DR : TAP_PAUSE_DR;
      TAP_EXIT2_DR: return tms ? TAP_UPD_DR   : TAP_SHIFT_DR;
      TAP_UPD_DR:   return tms ? TAP_SEL_DR   : TAP_IDLE;
      TAP_SEL_IR:   return tms ? TAP_RESET    : TAP_CAP_IR;
      TAP_CAP_IR:   return tms ? TAP_EXIT1_IR : TAP_SHIFT_IR;
      TAP_SHIFT_IR: return tms ? TAP_EXIT1_IR : TAP_SHIFT_IR;
      TAP_EXIT1_IR: return tms ? TAP_UPD_IR   : TAP_PAUSE_IR;
      TAP_PAUSE_IR: return tms ? TAP_EXIT2_IR : TAP_PAUSE_IR;
      TAP_EXIT2_IR: return tms ? TAP_UPD_IR   : TAP_SHIFT_IR;
      default:      return tms ? TAP_SEL_DR   : TAP_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/jtag_axi_host_if.sv
// rtl/jtag_axi_host_if.sv - command/response bus of the JTAG host (master issues, slave executes)
interface jtag_axi_host_if #(
  parameter int IR_WIDTH     = 4,
  parameter int DR_MAX_WIDTH = 64
);
  localparam int LEN_W = $clog2(DR_MAX_WIDTH + 1);

  logic                    cmd_valid;
  logic                    cmd_ready;
  logic [IR_WIDTH-1:0]     cmd_ir;
  logic                    cmd_skip_ir;
  logic [LEN_W-1:0]        cmd_dr_len;
  logic [DR_MAX_WIDTH-1:0] cmd_dr_data;
  logic                    rsp_valid;
  logic                    rsp_ready;
  logic [DR_MAX_WIDTH-1:0] rsp_dr_data;

  modport master (
    output cmd_valid, cmd_ir, cmd_skip_ir, cmd_dr_len, cmd_dr_data, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_dr_data
  );

  modport slave (
    input  cmd_valid, cmd_ir, cmd_skip_ir, cmd_dr_len, cmd_dr_data, rsp_ready,
    output cmd_ready, rsp_valid, rsp_dr_data
  );
endinterface

// File: rtl/jtag_axi_host_tck_gen.sv
// rtl/jtag_axi_host_tck_gen.sv - TCK divider; strobes mark the clk cycle in which TCK rises/falls
module jtag_axi_host_tck_gen
  import jtag_axi_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tck,
  output logic rise_stb,
  output logic fall_stb
);
  logic [DIV_CNT_W-1:0] div_cnt;
  logic                 wrap;

  assign wrap     = en && (div_cnt == DIV_CNT_W'(CLK_DIV - 1));
  assign rise_stb = wrap && !tck;
  assign fall_stb = wrap && tck;

  // Dropping en parks TCK low and restarts the half-period from zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
      tck     <= 1'b0;
    end else if (!en) begin
      div_cnt <= '0;
      tck     <= 1'b0;
    end else if (wrap) begin
      div_cnt <= '0;
      tck     <= ~tck;
    end else begin
      div_cnt <= div_cnt + DIV_CNT_W'(1);
    end
  end
endmodule

// File: rtl/jtag_axi_host.sv
// rtl/jtag_axi_host.sv - command-driven JTAG IR/DR scan host; JTAG_AXI_HOST_TRST_EN adds a TRST pulse
module jtag_axi_host
  import jtag_axi_pkg::*;
#(
  parameter int CLK_DIV      = 2,
  parameter int IR_WIDTH     = 4,
  parameter int DR_MAX_WIDTH = 64
) (
  input  logic           clk,
  input  logic           rst,
  jtag_axi_host_if.slave host_if,
  output logic           jtag_tck,
  output logic           jtag_tms,
  output logic           jtag_tdi,
  input  logic           jtag_tdo,
  output logic           jtag_trstn
);
  localparam int LEN_W = $clog2(DR_MAX_WIDTH + 1);
  localparam int IR_CW = $clog2(IR_WIDTH + 1);
  localparam int MAX_W = (LEN_W > IR_CW) ? LEN_W : IR_CW;
  localparam int CNT_W = (MAX_W > 3) ? MAX_W : 3;

  host_state_t             state, nxt_state;
  logic [CNT_W-1:0]        cnt, nxt_cnt;
  logic [LEN_W-1:0]        dr_len, len_sat;
  logic [IR_WIDTH-1:0]     ir_sr, ir_shr;
  logic [DR_MAX_WIDTH-1:0] dr_sr, dr_shr, cap_mask, rsp_data;
  logic                    running, rise_stb, fall_stb, last_tck;

  assign running = !(state == ST_IDLE || state == ST_RESP);
  assign len_sat = (host_if.cmd_dr_len > LEN_W'(DR_MAX_WIDTH)) ? LEN_W'(DR_MAX_WIDTH)
                                                               : host_if.cmd_dr_len;
  assign ir_shr  = ir_sr >> 1;
  assign dr_shr  = dr_sr >> 1;

  assign host_if.cmd_ready   = (state == ST_IDLE);
  assign host_if.rsp_valid   = (state == ST_RESP);
  assign host_if.rsp_dr_data = rsp_data;

  jtag_axi_host_tck_gen #(.CLK_DIV(CLK_DIV)) u_tck_gen (
    .clk      (clk),
    .rst      (rst),
    .en       (running),
    .tck      (jtag_tck),
    .rise_stb (rise_stb),
    .fall_stb (fall_stb)
  );

  // TMS carried by TCK number c of a state.
  function automatic logic tms_for(host_state_t st, logic [CNT_W-1:0] c, logic [LEN_W-1:0] len);
    case (st)
      ST_INIT:     return c < CNT_W'(5);
      ST_IR_NAV:   return c < CNT_W'(2);
      ST_IR_SHIFT: return c == CNT_W'(IR_WIDTH - 1);
      ST_DR_SHIFT: return c == CNT_W'(len) - CNT_W'(1);
      default:     return c == '0;
    endcase
  endfunction

  always_comb begin
    last_tck = 1'b0;
    case (state)
      ST_INIT:                  last_tck = (cnt == CNT_W'(5));
      ST_IR_NAV:                last_tck = (cnt == CNT_W'(3));
      ST_IR_SHIFT, ST_DR_SHIFT: last_tck = jtag_tms;  // shifts end on the TCK carrying TMS=1
      ST_IR_EXIT, ST_DR_EXIT:   last_tck = (cnt == CNT_W'(1));
      ST_DR_NAV:                last_tck = (cnt == CNT_W'(2));
      default:                  last_tck = 1'b0;
    endcase
  end

  always_comb begin
    nxt_state = state;
    nxt_cnt   = cnt + CNT_W'(1);
    if (last_tck) begin
      nxt_cnt = '0;
      case (state)
        ST_INIT:     nxt_state = ST_IDLE;
        ST_IR_NAV:   nxt_state = ST_IR_SHIFT;
        ST_IR_SHIFT: nxt_state = ST_IR_EXIT;
        ST_IR_EXIT:  nxt_state = (dr_len == '0) ? ST_RESP : ST_DR_NAV;
        ST_DR_NAV:   nxt_state = ST_DR_SHIFT;
        ST_DR_SHIFT: nxt_state = ST_DR_EXIT;
        ST_DR_EXIT:  nxt_state = ST_RESP;
        default:     nxt_state = state;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_INIT;
      cnt      <= '0;
      jtag_tms <= 1'b1;
      jtag_tdi <= 1'b0;
      dr_len   <= '0;
      ir_sr    <= '0;
      dr_sr    <= '0;
      cap_mask <= '0;
      rsp_data <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (host_if.cmd_valid) begin
            ir_sr    <= host_if.cmd_ir;
            dr_sr    <= host_if.cmd_dr_data;
            dr_len   <= len_sat;
            rsp_data <= '0;
            cnt      <= '0;
            if (host_if.cmd_skip_ir && len_sat == '0) begin
              state <= ST_RESP;
            end else begin
              state    <= host_if.cmd_skip_ir ? ST_DR_NAV : ST_IR_NAV;
              jtag_tms <= 1'b1;
            end
          end
        end
        ST_RESP: begin
          if (host_if.rsp_ready) state <= ST_IDLE;
        end
        default: begin
          // rsp_data accumulates one-hot so bit i is the i-th DR shift sample.
          if (rise_stb && state == ST_DR_SHIFT) begin
            if (jtag_tdo) rsp_data <= rsp_data | cap_mask;
            cap_mask <= cap_mask << 1;
          end
          if (fall_stb) begin
            state    <= nxt_state;
            cnt      <= nxt_cnt;
            jtag_tdi <= 1'b0;
            if (nxt_state != ST_IDLE && nxt_state != ST_RESP)
              jtag_tms <= tms_for(nxt_state, nxt_cnt, dr_len);
            if (nxt_state == ST_IR_SHIFT) begin
              if (state == ST_IR_SHIFT) begin
                ir_sr    <= ir_shr;
                jtag_tdi <= ir_shr[0];
              end else begin
                jtag_tdi <= ir_sr[0];
              end
            end
            if (nxt_state == ST_DR_SHIFT) begin
              if (state == ST_DR_SHIFT) begin
                dr_sr    <= dr_shr;
                jtag_tdi <= dr_shr[0];
              end else begin
                jtag_tdi <= dr_sr[0];
                cap_mask <= DR_MAX_WIDTH'(1);
              end
            end
          end
        end
      endcase
    end
  end

`ifdef JTAG_AXI_HOST_TRST_EN
  logic trstn_q;

  // Released at the fall closing the second INIT TCK.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) trstn_q <= 1'b0;
    else if (fall_stb && state == ST_INIT && cnt == CNT_W'(1)) trstn_q <= 1'b1;
  end

  assign jtag_trstn = trstn_q;
`else
  assign jtag_trstn = 1'b1;
`endif
endmodule

// File: tb/tb_jtag_axi_host.sv
// tb/tb_jtag_axi_host.sv - directed bench for jtag_axi_host against a behavioural TAP
module tb_jtag_axi_host;
  import jtag_axi_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic jtag_tck, jtag_tms, jtag_tdi, jtag_trstn;
  logic tap_tdo = 1'b0;

  int checks = 0;
  int failures = 0;

  jtag_axi_host_if #(.IR_WIDTH(4), .DR_MAX_WIDTH(64)) bus ();

  jtag_axi_host #(.CLK_DIV(2), .IR_WIDTH(4), .DR_MAX_WIDTH(64)) dut (
    .clk        (clk),
    .rst        (rst),
    .host_if    (bus),
    .jtag_tck   (jtag_tck),
    .jtag_tms   (jtag_tms),
    .jtag_tdi   (jtag_tdi),
    .jtag_tdo   (tap_tdo),
    .jtag_trstn (jtag_trstn)
  );

  always #5 clk = ~clk;

  // Behavioural TAP: IDCODE, BYPASS and a 32-bit ADDR_AXI_REG data register.
  tap_ctrl_fsm_t tap_st   = TAP_RESET;
  ir_decoding_t  tap_ir   = IR_IDCODE;
  logic [3:0]    ir_shift = 4'd0;
  logic [63:0]   dr_shift = 64'd0;
  logic [31:0]   axi_reg  = 32'd0;

  always @(posedge jtag_tck) begin
    case (tap_st)
      TAP_RESET:    tap_ir <= IR_IDCODE;
      TAP_CAP_IR:   ir_shift <= 4'b0001;
      TAP_SHIFT_IR: ir_shift <= {jtag_tdi, ir_shift[3:1]};
      TAP_UPD_IR:   tap_ir <= ir_decoding_t'(ir_shift);
      TAP_CAP_DR: begin
        if (tap_ir == IR_IDCODE)            dr_shift <= 64'hBADC_0FFE;
        else if (tap_ir == IR_ADDR_AXI_REG) dr_shift <= {32'd0, axi_reg};
        else                                dr_shift <= 64'd0;
      end
      TAP_SHIFT_DR: begin
        if (tap_ir == IR_IDCODE || tap_ir == IR_ADDR_AXI_REG)
          dr_shift <= {32'd0, jtag_tdi, dr_shift[31:1]};
        else
          dr_shift <= {63'd0, jtag_tdi};
      end
      TAP_UPD_DR: if (tap_ir == IR_ADDR_AXI_REG) axi_reg <= dr_shift[31:0];
      default: ;
    endcase
    tap_st <= tap_next(tap_st, jtag_tms);
  end

  always @(negedge jtag_tck) begin
    if (tap_st == TAP_SHIFT_DR)      tap_tdo <= dr_shift[0];
    else if (tap_st == TAP_SHIFT_IR) tap_tdo <= ir_shift[0];
    else                             tap_tdo <= 1'b0;
  end

  // Pin monitor, sampled mid-cycle.
  int          cyc = 0;
  int          rise_cnt = 0;
  int          last_rise = 0;
  int          period = 0;
  int          pin_glitch = 0;
  logic [15:0] tms_log = 16'd0;
  logic        tck_prev = 1'b0, tms_prev = 1'b1, tdi_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (jtag_tck && !tck_prev) begin
      rise_cnt  <= rise_cnt + 1;
      period    <= cyc - last_rise;
      last_rise <= cyc;
      tms_log   <= {tms_log[14:0], jtag_tms};
    end
    if (jtag_tck && tck_prev && (jtag_tms != tms_prev || jtag_tdi != tdi_prev))
      pin_glitch <= pin_glitch + 1;
    tck_prev <= jtag_tck;
    tms_prev <= jtag_tms;
    tdi_prev <= jtag_tdi;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send_cmd(input logic [3:0] ir, input logic skip, input logic [6:0] len,
                          input logic [63:0] data);
    int n = 0;
    while (!bus.cmd_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("cmd_ready_wait", 64'(bus.cmd_ready), 64'd1);
    bus.cmd_valid   = 1'b1;
    bus.cmd_ir      = ir;
    bus.cmd_skip_ir = skip;
    bus.cmd_dr_len  = len;
    bus.cmd_dr_data = data;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic get_rsp(input int hold, output logic [63:0] d);
    int   n = 0;
    int   r0;
    logic stable;
    while (!bus.rsp_valid && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("rsp_valid_wait", 64'(bus.rsp_valid), 64'd1);
    d = bus.rsp_dr_data;
    if (hold > 0) begin
      r0 = rise_cnt;
      stable = 1'b1;
      repeat (hold) begin
        @(negedge clk);
        if (!bus.rsp_valid || bus.rsp_dr_data !== d || bus.cmd_ready || jtag_tck) stable = 1'b0;
      end
      check("hold_stable", 64'(stable), 64'd1);
      check("hold_no_tck", 64'(rise_cnt - r0), 64'd0);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
  endtask

  initial begin
    logic [63:0] d;
    int          base, n;
    logic        seen;
    logic        trst_exp;

    bus.cmd_valid   = 1'b0;
    bus.cmd_ir      = 4'd0;
    bus.cmd_skip_ir = 1'b0;
    bus.cmd_dr_len  = 7'd0;
    bus.cmd_dr_data = 64'd0;
    bus.rsp_ready   = 1'b0;
`ifdef JTAG_AXI_HOST_TRST_EN
    trst_exp = 1'b0;
`else
    trst_exp = 1'b1;
`endif

    repeat (2) @(negedge clk);
    check("rst_tck", 64'(jtag_tck), 64'd0);
    check("rst_tms", 64'(jtag_tms), 64'd1);
    check("rst_tdi", 64'(jtag_tdi), 64'd0);
    check("rst_cmd_ready", 64'(bus.cmd_ready), 64'd0);
    check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("rst_rsp_data", bus.rsp_dr_data, 64'd0);
    check("rst_trstn", 64'(jtag_trstn), 64'(trst_exp));

    base = rise_cnt;
    rst = 1'b0;
    n = 0;
    while (!bus.cmd_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("init_tck_count", 64'(rise_cnt - base), 64'd6);
    check("init_tms_seq", 64'(tms_log[5:0]), 64'b111110);
    check("init_tck_period", 64'(period), 64'd4);
    check("init_trstn", 64'(jtag_trstn), 64'd1);

    base = rise_cnt;
    send_cmd(4'(IR_IDCODE), 1'b0, 7'd32, 64'd0);
    get_rsp(20, d);
    check("idcode", d, 64'hBADC_0FFE);
    check("idcode_tcks", 64'(rise_cnt - base), 64'd47);

    send_cmd(4'(IR_BYPASS), 1'b0, 7'd8, 64'hA5);
    get_rsp(0, d);
    check("bypass8", d, 64'h4A);

    base = rise_cnt;
    send_cmd(4'(IR_BYPASS), 1'b1, 7'd100, 64'h8000_0000_0000_0003);
    get_rsp(0, d);
    check("len_saturate", d, 64'h6);
    check("len_saturate_tcks", 64'(rise_cnt - base), 64'd69);

    send_cmd(4'(IR_ADDR_AXI_REG), 1'b0, 7'd32, 64'h1234_5678);
    get_rsp(0, d);
    check("addr_write_old", d, 64'd0);
    send_cmd(4'(IR_BYPASS), 1'b1, 7'd32, 64'd0);
    get_rsp(0, d);
    check("addr_rescan", d, 64'h1234_5678);

    base = rise_cnt;
    send_cmd(4'(IR_BYPASS), 1'b1, 7'd0, 64'hFFFF);
    get_rsp(0, d);
    check("empty_cmd_data", d, 64'd0);
    check("empty_cmd_tcks", 64'(rise_cnt - base), 64'd0);

    send_cmd(4'(IR_IDCODE), 1'b0, 7'd32, 64'd0);
    base = rise_cnt;
    n = 0;
    while (rise_cnt < base + 20 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("abort_reach_shift", 64'(n < 1000), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    check("abort_tck", 64'(jtag_tck), 64'd0);
    check("abort_tms", 64'(jtag_tms), 64'd1);
    check("abort_tdi", 64'(jtag_tdi), 64'd0);
    check("abort_cmd_ready", 64'(bus.cmd_ready), 64'd0);
    check("abort_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("abort_rsp_data", bus.rsp_dr_data, 64'd0);
    @(negedge clk);
    base = rise_cnt;
    rst = 1'b0;
    seen = 1'b0;
    n = 0;
    while (!bus.cmd_ready && n < 500) begin
      @(negedge clk);
      if (bus.rsp_valid) seen = 1'b1;
      n++;
    end
    check("reinit_tck_count", 64'(rise_cnt - base), 64'd6);
    check("reinit_no_rsp", 64'(seen), 64'd0);

    send_cmd(4'(IR_BYPASS), 1'b1, 7'd32, 64'd0);
    get_rsp(0, d);
    check("reinit_idcode", d, 64'hBADC_0FFE);

    check("pins_stable_tck_high", 64'(pin_glitch), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
